// File: rtl/fc8_input_scanner.sv
// FC8 input scanner: per-channel polarity, 2-flop sync, debounce, press/release/auto-repeat
// pulses, and a sticky write-one-to-clear event register driving a registered IRQ.
module fc8_input_scanner #(
  parameter int                NUM_CH          = 6,
  parameter int                DEBOUNCE_CYCLES = 50000,
  parameter int                REPEAT_DELAY    = 2500000,
  parameter int                REPEAT_PERIOD   = 500000,
  parameter logic [NUM_CH-1:0] INVERT_MASK     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic [NUM_CH-1:0] repeat_en,
  input  logic              evt_clr,
  input  logic [NUM_CH-1:0] evt_clr_mask,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] repeat_pulse,
  output logic [NUM_CH-1:0] evt_pending,
  output logic              irq
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST   = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic {RPT_DELAY, RPT_PERIOD} rpt_state_e;

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] clr_bits;

  // Polarity fix-up happens before the first flop so idle-high pins read as released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in ^ INVERT_MASK;
      sync2 <= sync1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : gen_ch
    logic [DB_W-1:0]  db_cnt;
    logic [DB_W-1:0]  db_cnt_next;
    logic             commit;
    logic             lvl_q;
    logic             press_q;
    logic             release_q;
    logic             rpt_q;
    rpt_state_e       state;
    rpt_state_e       state_next;
    logic [RPT_W-1:0] hold_cnt;
    logic [RPT_W-1:0] hold_next;
    logic             fire;

    always_comb begin
      db_cnt_next = '0;
      commit      = 1'b0;
      if (sync2[ch] != lvl_q) begin
        if (db_cnt == DB_LAST) begin
          commit = 1'b1;
        end else begin
          db_cnt_next = db_cnt + DB_W'(1);
        end
      end
    end

    // A press commit happens while lvl_q is still 0, so repeat can never fire with it.
    always_comb begin
      state_next = state;
      hold_next  = hold_cnt;
      fire       = 1'b0;
      if (commit && sync2[ch]) begin
        state_next = RPT_DELAY;
        hold_next  = '0;
      end else if (!lvl_q || !repeat_en[ch]) begin
        state_next = RPT_DELAY;
        hold_next  = '0;
      end else if (state == RPT_DELAY) begin
        if (hold_cnt == DELAY_LAST) begin
          fire       = 1'b1;
          hold_next  = '0;
          state_next = RPT_PERIOD;
        end else begin
          hold_next = hold_cnt + RPT_W'(1);
        end
      end else begin
        if (hold_cnt == PER_LAST) begin
          fire      = 1'b1;
          hold_next = '0;
        end else begin
          hold_next = hold_cnt + RPT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt    <= '0;
        lvl_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        rpt_q     <= 1'b0;
        state     <= RPT_DELAY;
        hold_cnt  <= '0;
      end else begin
        db_cnt    <= db_cnt_next;
        lvl_q     <= commit ? sync2[ch] : lvl_q;
        press_q   <= commit & sync2[ch];
        release_q <= commit & ~sync2[ch];
        rpt_q     <= fire;
        state     <= state_next;
        hold_cnt  <= hold_next;
      end
    end

    assign level[ch]         = lvl_q;
    assign press_pulse[ch]   = press_q;
    assign release_pulse[ch] = release_q;
    assign repeat_pulse[ch]  = rpt_q;
  end

  assign clr_bits = evt_clr ? evt_clr_mask : '0;

  // New events take priority over a clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_pending <= '0;
      irq         <= 1'b0;
    end else begin
      evt_pending <= press_pulse | repeat_pulse | (evt_pending & ~clr_bits);
      irq         <= |evt_pending;
    end
  end

endmodule

// File: doc/fc8_input_scanner.md
Name: fc8_input_scanner

Overview:
- Parametrised successor to the FC8 joystick/button input controller. Handles NUM_CH raw inputs with per-channel input polarity.
- Each channel passes through a 2-flop synchroniser and a configurable debouncer. The block then produces press, release and auto-repeat pulses.
- Press/repeat events are held in a sticky pending register with write-one-to-clear and an IRQ output.
- Sits between the board pins and the CPU I/O register decode. The CPU reads `level` as the status byte and `evt_pending` as the event register.

Parameters:
- NUM_CH, 6: number of input channels, 1..16.
- DEBOUNCE_CYCLES, 50000: cycles a synchronised input must differ from `level` before it commits, >=1.
- REPEAT_DELAY, 2500000: cycles from press to first auto-repeat pulse, >=1.
- REPEAT_PERIOD, 500000: cycles between subsequent auto-repeat pulses, >=1.
- INVERT_MASK, {NUM_CH{1'b0}}: per channel, 1 = raw input is active-low and is inverted before the synchroniser.

Ports:
- clk, input, 1: system clock; the only clock.
- rst, input, 1: synchronous, active-high reset.
- raw_in, input, NUM_CH: asynchronous raw pin inputs.
- repeat_en, input, NUM_CH: per-channel auto-repeat enable.
- evt_clr, input, 1: strobe; clear pending bits selected by evt_clr_mask.
- evt_clr_mask, input, NUM_CH: write-one-to-clear mask, sampled when evt_clr=1.
- level, output, NUM_CH: debounced level, 1 = pressed.
- press_pulse, output, NUM_CH: one-cycle pulse on debounced 0->1.
- release_pulse, output, NUM_CH: one-cycle pulse on debounced 1->0.
- repeat_pulse, output, NUM_CH: one-cycle auto-repeat pulse.
- evt_pending, output, NUM_CH: sticky event flags.
- irq, output, 1: OR of evt_pending.

Behaviour:
- Reset (rst=1 at a clk edge): sync flops, level, all pulse outputs, evt_pending, and all counters go to 0. irq=0 in the following cycle. Reset asserted mid-debounce or mid-repeat aborts it with no pulse.
- Polarity: s = raw_in ^ INVERT_MASK. Channels with an idle-high active-low raw input show no spurious press after reset.
- Synchroniser: s -> sync1 -> sync2, two flops per channel.
- Debounce counter, per channel, width $clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == level, the counter goes to 0.
  - Else if counter == DEBOUNCE_CYCLES-1, level <= sync2 and counter <= 0 (commit).
  - Else the counter increments.
  - Any glitch back to the level value before commit restarts the count.
- Latency: the edge that first samples the new raw value is edge 1; level changes on edge DEBOUNCE_CYCLES+2.
- Edge pulses: registered and asserted in the same cycle level first shows its new value. press_pulse on a 0->1 commit, release_pulse on a 1->0 commit; each is high for exactly one cycle.
- Auto-repeat, per channel, hold counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1), two-state FSM {DELAY, PERIOD}:
  - On a press commit: counter=0, state=DELAY.
  - DELAY: each cycle with level=1 and repeat_en=1 the counter increments. When it would reach REPEAT_DELAY, assert repeat_pulse, set counter=0, state=PERIOD.
  - PERIOD: same rule against REPEAT_PERIOD, staying in PERIOD.
  - Resulting timing: press_pulse at cycle T gives repeat_pulse at T+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
  - level=0 or repeat_en=0: counter=0, state=DELAY, no repeat_pulse.
  - Re-asserting repeat_en while held gives the first repeat REPEAT_DELAY cycles later.
  - repeat_pulse never coincides with press_pulse.
- Pending register, per bit:
  - Set when press_pulse or repeat_pulse is high.
  - Else cleared when evt_clr=1 and the mask bit is 1.
  - Set wins over a same-cycle clear. Release does not set pending.
- irq is registered: it equals the OR of evt_pending, one cycle later. Clearing all pending bits drops irq one cycle after evt_pending clears.
- Channels are fully independent. Simultaneous commits on several channels each produce their own pulses in the same cycle.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, NUM_CH=6, INVERT_MASK=6'b100000):
1. Reset with raw_in=6'b100000 (ch5 idle-high) held 20 cycles -> level=0, no pulses, evt_pending=0, irq=0.
2. raw_in[0] rises and is held -> level[0] rises on edge 6 counting from the first sampling edge; press_pulse[0]=1 for one cycle; evt_pending[0]=1; irq=1 on the next cycle.
3. raw_in[1] high 3 cycles, low 1, high 3, then low -> level[1] stays 0 and no press_pulse (counter restarts on each glitch).
4. Ch0 held with repeat_en[0]=1, press at cycle T -> repeat_pulse[0] at T+10, T+15, T+20. Deasserting repeat_en at T+17 suppresses T+20. Reasserting at T+22 gives the next repeat at T+32.
5. evt_clr=1 with mask=6'b000001 in the same cycle as repeat_pulse[0] -> evt_pending[0] stays 1. The same clear one cycle later -> bit 0 clears and irq falls the following cycle.
6. Ch2 and ch3 rise together, then rst for 1 cycle mid-debounce -> no press pulses. After release from reset with the inputs still high, presses on both channels arrive DEBOUNCE_CYCLES+2 edges later, in the same cycle.
